// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline buffers.
// Holds the buffer state encoding, per-stage payload widths, bit positions of
// the control fields inside a control word, and pack/unpack helpers for the
// ID/EX payloads so producers and consumers agree on the layout.
package cpu_pipe_pkg;

  // Occupancy of a pipeline buffer: nothing held, main entry only, or main
  // plus skid entry.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipeState_t;

  // Per-stage payload widths.
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 16;
  localparam int IDEX_DATA_W  = 96;
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_DATA_W = 96;
  localparam int EXMEM_CTRL_W = 16;
  localparam int MEMWB_DATA_W = 64;
  localparam int MEMWB_CTRL_W = 16;

  // Bit positions of the control fields within a control word.
  localparam int REG_WRITE_BIT = 0;
  localparam int MEMTO_REG_BIT = 1;
  localparam int PC_TO_REG_BIT = 2;
  localparam int BRANCH_N_BIT  = 3;
  localparam int BRANCH_Z_BIT  = 4;
  localparam int JUMP_BIT      = 5;
  localparam int JUMP_MEM_BIT  = 6;
  localparam int MEM_READ_BIT  = 7;
  localparam int MEM_WRITE_BIT = 8;
  localparam int ALUOP_LSB     = 9;
  localparam int ALUOP_W       = 4;

  typedef struct packed {
    logic               regWrite;
    logic               memtoReg;
    logic               PCtoReg;
    logic               branchN;
    logic               branchZ;
    logic               jump;
    logic               jumpMem;
    logic               memRead;
    logic               memWrite;
    logic [ALUOP_W-1:0] aluOp;
  } idexCtrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
  } idexData_t;

  // Spare control bits above the ALU op field are always packed as zero.
  function automatic logic [IDEX_CTRL_W-1:0] packIdExCtrl(input idexCtrl_t c);
    logic [IDEX_CTRL_W-1:0] v;
    v = '0;
    v[REG_WRITE_BIT]            = c.regWrite;
    v[MEMTO_REG_BIT]            = c.memtoReg;
    v[PC_TO_REG_BIT]            = c.PCtoReg;
    v[BRANCH_N_BIT]             = c.branchN;
    v[BRANCH_Z_BIT]             = c.branchZ;
    v[JUMP_BIT]                 = c.jump;
    v[JUMP_MEM_BIT]             = c.jumpMem;
    v[MEM_READ_BIT]             = c.memRead;
    v[MEM_WRITE_BIT]            = c.memWrite;
    v[ALUOP_LSB +: ALUOP_W]     = c.aluOp;
    return v;
  endfunction

  function automatic idexCtrl_t unpackIdExCtrl(input logic [IDEX_CTRL_W-1:0] v);
    idexCtrl_t c;
    c.regWrite = v[REG_WRITE_BIT];
    c.memtoReg = v[MEMTO_REG_BIT];
    c.PCtoReg  = v[PC_TO_REG_BIT];
    c.branchN  = v[BRANCH_N_BIT];
    c.branchZ  = v[BRANCH_Z_BIT];
    c.jump     = v[JUMP_BIT];
    c.jumpMem  = v[JUMP_MEM_BIT];
    c.memRead  = v[MEM_READ_BIT];
    c.memWrite = v[MEM_WRITE_BIT];
    c.aluOp    = v[ALUOP_LSB +: ALUOP_W];
    return c;
  endfunction

  function automatic logic [IDEX_DATA_W-1:0] packIdExData(input idexData_t d);
    return {d.pc, d.rs, d.rt};
  endfunction

  function automatic idexData_t unpackIdExData(input logic [IDEX_DATA_W-1:0] v);
    idexData_t d;
    d.pc = v[95:64];
    d.rs = v[63:32];
    d.rt = v[31:0];
    return d;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for pipeline statistics.
// Ports:
//   clk     - clock, counts on the falling edge like the pipeline buffers
//   rst_n   - asynchronous active-low reset, clears the count
//   i_inc   - add one this edge (ignored once the count is all ones)
//   i_clr   - synchronous clear, wins over i_inc
//   o_count - current count
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  // Stop at all ones instead of wrapping so a long stall never reads as short.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline buffer placed between two CPU pipeline stages.
// Carries a datapath payload and a control payload with a valid/ready
// handshake, an optional skid entry for full throughput under back-pressure,
// a synchronous flush that turns held entries into bubbles, and a saturating
// stall counter. All state changes on the falling clock edge.
// Ports:
//   clk, rst_n          - clock (falling edge) and async active-low reset
//   in_valid/in_ready   - upstream handshake
//   data_in/ctrl_in     - upstream payload
//   flush               - kill every held entry at the next edge
//   out_valid/out_ready - downstream handshake
//   data_out/ctrl_out   - main entry payload; ctrl_out is zero in bubbles
//   stat_clr/stall_cnt  - clear and value of the back-pressure counter
module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W  = IDEX_DATA_W,
  parameter int CTRL_W  = IDEX_CTRL_W,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipeState_t        r_state;
  pipeState_t        w_nextState;
  logic [DATA_W-1:0] r_mainData;
  logic [CTRL_W-1:0] r_mainCtrl;
  logic [DATA_W-1:0] r_skidData;
  logic [CTRL_W-1:0] r_skidCtrl;
  logic              w_inReady;
  logic              w_accept;
  logic              w_drain;
  logic              w_loadMainIn;
  logic              w_loadMainSkid;
  logic              w_loadSkid;

  assign out_valid = (r_state != EMPTY);

  // With a skid entry, in_ready depends only on state, which cuts the
  // combinational ready path back to the producer. Without it, a slot frees
  // up in the same cycle the consumer takes the main entry.
  assign w_inReady = SKID_EN ? (r_state != TWO) : (!out_valid || out_ready);
  assign in_ready  = w_inReady;

  assign w_accept = in_valid && w_inReady;
  assign w_drain  = out_valid && out_ready;

  // State register.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and entry load selects. Flush overrides everything; an entry
  // accepted on a flush edge is simply never loaded.
  always_comb begin
    w_nextState    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    if (flush) begin
      w_nextState = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_nextState  = ONE;
            w_loadMainIn = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_loadMainIn = 1'b1;
          end else if (w_accept) begin
            if (SKID_EN) begin
              w_nextState = TWO;
              w_loadSkid  = 1'b1;
            end
          end else if (w_drain) begin
            w_nextState = EMPTY;
          end
        end
        TWO: begin
          if (w_drain) begin
            w_nextState    = ONE;
            w_loadMainSkid = 1'b1;
          end
        end
        default: begin
          w_nextState = EMPTY;
        end
      endcase
    end
  end

  // Entry storage. Flush only clears control so a killed slot carries no
  // write enables; the data is don't-care once the slot is invalid.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainData <= '0;
      r_mainCtrl <= '0;
      r_skidData <= '0;
      r_skidCtrl <= '0;
    end else if (flush) begin
      r_mainCtrl <= '0;
      r_skidCtrl <= '0;
    end else begin
      if (w_loadMainIn) begin
        r_mainData <= data_in;
        r_mainCtrl <= ctrl_in;
      end else if (w_loadMainSkid) begin
        r_mainData <= r_skidData;
        r_mainCtrl <= r_skidCtrl;
      end
      if (w_loadSkid) begin
        r_skidData <= data_in;
        r_skidCtrl <= ctrl_in;
      end
    end
  end

  assign data_out = r_mainData;
  assign ctrl_out = out_valid ? r_mainCtrl : '0;

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stallCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (out_valid && !out_ready),
    .i_clr  (stat_clr),
    .o_count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf. One instance with the skid entry and a
// 4-bit stall counter, one without the skid entry; both share the stimulus.
module tb_pipe_stage_buf;

  logic       clk;
  logic       rstN;
  logic       inValid;
  logic [7:0] dataIn;
  logic [3:0] ctrlIn;
  logic       flush;
  logic       outReady;
  logic       statClr;

  logic       inReady,  inReady0;
  logic       outValid, outValid0;
  logic [7:0] dataOut,  dataOut0;
  logic [3:0] ctrlOut,  ctrlOut0;
  logic [3:0] stallCnt, stallCnt0;

  int errors = 0;
  int checks = 0;

  pipe_stage_buf #(.DATA_W(8), .CTRL_W(4), .SKID_EN(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
    .data_in(dataIn), .ctrl_in(ctrlIn), .flush(flush), .out_valid(outValid),
    .out_ready(outReady), .data_out(dataOut), .ctrl_out(ctrlOut),
    .stat_clr(statClr), .stall_cnt(stallCnt)
  );

  pipe_stage_buf #(.DATA_W(8), .CTRL_W(4), .SKID_EN(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady0),
    .data_in(dataIn), .ctrl_in(ctrlIn), .flush(flush), .out_valid(outValid0),
    .out_ready(outReady), .data_out(dataOut0), .ctrl_out(ctrlOut0),
    .stat_clr(statClr), .stall_cnt(stallCnt0)
  );

  // Falling edges at 10, 20, 30 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] c,
                               input logic f, input logic r, input logic clr);
    inValid  = v;
    dataIn   = d;
    ctrlIn   = c;
    flush    = f;
    outReady = r;
    statClr  = clr;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
    #3;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_data_out", 32'(dataOut), 32'h0);
    checkOutput("rst_ctrl_out", 32'(ctrlOut), 32'h0);
    checkOutput("rst_stall_cnt", 32'(stallCnt), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("rst_in_ready_noskid", 32'(inReady0), 32'd1);
    #4;
    rstN = 1'b1;

    $display("[TB] stream with out_ready high");
    applyStimulus(1'b1, 8'hA1, 4'h1, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("s1_valid", 32'(outValid), 32'd1);
    checkOutput("s1_data", 32'(dataOut), 32'hA1);
    checkOutput("s1_ctrl", 32'(ctrlOut), 32'h1);
    applyStimulus(1'b1, 8'hA2, 4'h2, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("s2_data", 32'(dataOut), 32'hA2);
    checkOutput("s2_in_ready", 32'(inReady), 32'd1);
    applyStimulus(1'b1, 8'hA3, 4'h3, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("s3_data", 32'(dataOut), 32'hA3);
    checkOutput("s3_ctrl", 32'(ctrlOut), 32'h3);
    checkOutput("s3_stall", 32'(stallCnt), 32'd0);
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("s4_empty_valid", 32'(outValid), 32'd0);
    checkOutput("s4_bubble_ctrl", 32'(ctrlOut), 32'h0);

    $display("[TB] back-pressure into the skid entry");
    applyStimulus(1'b1, 8'hB1, 4'h5, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("bp1_data", 32'(dataOut), 32'hB1);
    checkOutput("bp1_stall", 32'(stallCnt), 32'd0);
    applyStimulus(1'b1, 8'hB2, 4'h6, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("bp2_in_ready", 32'(inReady), 32'd0);
    checkOutput("bp2_data_held", 32'(dataOut), 32'hB1);
    checkOutput("bp2_ctrl_held", 32'(ctrlOut), 32'h5);
    checkOutput("bp2_stall", 32'(stallCnt), 32'd1);
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("bp3_data_held", 32'(dataOut), 32'hB1);
    checkOutput("bp3_stall", 32'(stallCnt), 32'd2);
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("bp4_data", 32'(dataOut), 32'hB2);
    checkOutput("bp4_ctrl", 32'(ctrlOut), 32'h6);
    checkOutput("bp4_in_ready", 32'(inReady), 32'd1);
    step();
    checkOutput("bp5_empty", 32'(outValid), 32'd0);
    checkOutput("bp5_stall", 32'(stallCnt), 32'd2);

    $display("[TB] flush while full");
    applyStimulus(1'b1, 8'hC1, 4'h7, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 8'hC2, 4'h8, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("fl_full_in_ready", 32'(inReady), 32'd0);
    checkOutput("fl_full_stall", 32'(stallCnt), 32'd3);
    applyStimulus(1'b1, 8'hC3, 4'h9, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("fl_valid", 32'(outValid), 32'd0);
    checkOutput("fl_ctrl", 32'(ctrlOut), 32'h0);
    checkOutput("fl_in_ready", 32'(inReady), 32'd1);
    checkOutput("fl_stall_kept", 32'(stallCnt), 32'd4);
    applyStimulus(1'b1, 8'hC4, 4'hA, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("fl_accept_dropped", 32'(outValid), 32'd0);
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("fl_no_c3", 32'(outValid), 32'd0);

    $display("[TB] stall counter saturation");
    applyStimulus(1'b1, 8'hE1, 4'hB, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    checkOutput("sat_stall", 32'(stallCnt), 32'd15);
    checkOutput("sat_data_held", 32'(dataOut), 32'hE1);
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("clr_stall", 32'(stallCnt), 32'd0);
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("clr_restart", 32'(stallCnt), 32'd1);

    $display("[TB] asynchronous reset while full");
    applyStimulus(1'b1, 8'hE2, 4'hC, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("ar_full_in_ready", 32'(inReady), 32'd0);
    checkOutput("ar_full_stall", 32'(stallCnt), 32'd2);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(outValid), 32'd0);
    checkOutput("ar_ctrl", 32'(ctrlOut), 32'h0);
    checkOutput("ar_stall", 32'(stallCnt), 32'd0);
    checkOutput("ar_in_ready", 32'(inReady), 32'd1);
    #1;
    rstN = 1'b1;
    applyStimulus(1'b1, 8'hF1, 4'hD, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("ar_first_data", 32'(dataOut), 32'hF1);
    checkOutput("ar_first_valid", 32'(outValid), 32'd1);

    $display("[TB] single-entry variant");
    checkOutput("ns_valid", 32'(outValid0), 32'd1);
    checkOutput("ns_data_f1", 32'(dataOut0), 32'hF1);
    applyStimulus(1'b1, 8'hD2, 4'h4, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("ns_in_ready_comb", 32'(inReady0), 32'd1);
    step();
    checkOutput("ns_data_d2", 32'(dataOut0), 32'hD2);
    checkOutput("ns_ctrl_d2", 32'(ctrlOut0), 32'h4);
    applyStimulus(1'b1, 8'hD3, 4'h5, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("ns_in_ready_low", 32'(inReady0), 32'd0);
    checkOutput("skid_in_ready_high", 32'(inReady), 32'd1);
    step();
    checkOutput("ns_data_held", 32'(dataOut0), 32'hD2);
    checkOutput("ns_stall", 32'(stallCnt0), 32'd1);
    checkOutput("skid_to_two", 32'(inReady), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
